// File: rtl/i2s_tx.sv
// I2S master transmitter: generates scki/bck/lrck from clk and serialises
// one left/right pair per lrck frame (lrck low = left, MSB one bck after the
// lrck edge). Upstream feeds pairs through a one-entry hold buffer.
// Build option: define I2S_TX_UNDERRUN_ZERO_EN to send silence on underrun
// instead of repeating the previous pair.
module i2s_tx #(
  parameter int WIDTH   = 24,
  parameter int SLOT    = 32,
  parameter int BCK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             valid,
  output logic             ready,
  output logic             scki,
  output logic             bck,
  output logic             lrck,
  output logic             dout,
  output logic             underrun
);

  localparam int DW = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT);
  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [DW-1:0]    divcnt_q;
  logic [BW-1:0]    bitcnt_q;
  logic             bck_q, lrck_q, dout_q, underrun_q, ready_q;
  logic             full_q, first_q;
  logic [WIDTH-1:0] hold_l_q, hold_r_q, sh_l_q, sh_r_q;

  logic             div_wrap, boundary, accept, full_d, dout_d, lr_now, in_rng;
  logic [BW-1:0]    k;
  logic [BW-1:0]    pos;
  logic [WIDTH-1:0] ch;

  assign scki     = clk;
  assign bck      = bck_q;
  assign lrck     = lrck_q;
  assign dout     = dout_q;
  assign underrun = underrun_q;
  assign ready    = ready_q;

  assign div_wrap = (divcnt_q == DW'(BCK_DIV - 1));
  assign boundary = div_wrap && (bitcnt_q == BW'(2 * SLOT - 1));
  // ready mirrors "buffer empty", so an accept can never collide with a full buffer
  assign accept   = valid && ready_q;

  // Bit selection for the bit period the counters are in now; registered below
  always_comb begin
    lr_now = (bitcnt_q >= BW'(SLOT));
    k      = lr_now ? (bitcnt_q - BW'(SLOT)) : bitcnt_q;
    ch     = lr_now ? sh_r_q : sh_l_q;
    in_rng = (k != '0) && (k <= BW'(WIDTH));
    pos    = BW'(WIDTH) - k;
    dout_d = in_rng ? ch[pos[IW-1:0]] : 1'b0;
  end

  // Buffer occupancy: the boundary drains using the pre-accept state
  always_comb begin
    full_d = full_q;
    if (boundary && full_q) full_d = 1'b0;
    if (accept)             full_d = 1'b1;
  end

  // Counters, registered clocks/data, hold buffer and shadow registers
  always_ff @(posedge clk) begin
    if (reset) begin
      divcnt_q   <= '0;
      bitcnt_q   <= '0;
      bck_q      <= 1'b0;
      lrck_q     <= 1'b0;
      dout_q     <= 1'b0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b0;
      full_q     <= 1'b0;
      first_q    <= 1'b1;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      sh_l_q     <= '0;
      sh_r_q     <= '0;
    end else begin
      divcnt_q <= div_wrap ? '0 : divcnt_q + 1'b1;
      if (div_wrap)
        bitcnt_q <= (bitcnt_q == BW'(2 * SLOT - 1)) ? '0 : bitcnt_q + 1'b1;

      bck_q      <= (divcnt_q >= DW'(BCK_DIV / 2));
      lrck_q     <= lr_now;
      dout_q     <= dout_d;
      // the first boundary after reset has nothing to miss, so no underrun
      underrun_q <= boundary && !full_q && !first_q;
      full_q     <= full_d;
      ready_q    <= ~full_d;

      if (boundary) begin
        first_q <= 1'b0;
        if (full_q) begin
          sh_l_q <= hold_l_q;
          sh_r_q <= hold_r_q;
        end else if (!first_q) begin
`ifdef I2S_TX_UNDERRUN_ZERO_EN
          sh_l_q <= '0;
          sh_r_q <= '0;
`endif
        end
      end

      if (accept) begin
        hold_l_q <= left;
        hold_r_q <= right;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: random pairs and gaps, a frame-level reference model
// feeding a queue of expected (lrck,dout) per bck rising edge, and a monitor
// that pops and compares at each observed bck rise.
module tb_i2s_tx;

  localparam int FRAME = 256;  // clk per lrck frame with BCK_DIV=4, SLOT=32

  logic        clk, reset, valid, ready, scki, bck, lrck, dout, underrun;
  logic [23:0] left, right;

  int chk_n = 0;
  int err_n = 0;

  i2s_tx #(.WIDTH(24), .SLOT(32), .BCK_DIV(4)) dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .valid(valid),
    .ready(ready), .scki(scki), .bck(bck), .lrck(lrck), .dout(dout),
    .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // cyc = posedges since the last edge that sampled reset high. A pair
  // accepted at edge cyc goes out in frame cyc/256+1; frame m begins at
  // edge 256*m. Frames without a new pair repeat (or silence) the last one.
  int          cyc;
  logic        ur_exp;
  logic [47:0] pend [int];
  logic [1:0]  exp_q [$];
  logic [23:0] cur_l, cur_r;

  task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
    logic [31:0] slot;
    for (int c = 0; c < 2; c++) begin
      // slot layout: one blank bit, 24 sample bits MSB first, then padding
      slot = {1'b0, (c == 0) ? l : r, 7'b0};
      for (int b = 0; b < 32; b++) exp_q.push_back({c[0], slot[31-b]});
    end
  endtask

  initial begin
    int f, m;
    cyc = 0; ur_exp = 1'b0; cur_l = '0; cur_r = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        cyc = 0; ur_exp = 1'b0; cur_l = '0; cur_r = '0;
        exp_q.delete(); pend.delete();
      end else begin
        cyc++;
        ur_exp = 1'b0;
        if (valid && ready) begin
          f = cyc / FRAME + 1;
          chk_n++;
          if (pend.exists(f)) begin
            err_n++;
            $display("FAIL accept_slot: second pair accepted for frame %0d at cyc %0d", f, cyc);
          end
          pend[f] = {left, right};
        end
        if (cyc == 1) push_frame('0, '0);
        else if (cyc % FRAME == 0) begin
          m = cyc / FRAME;
          if (pend.exists(m)) begin
            {cur_l, cur_r} = pend[m];
            pend.delete(m);
          end else if (m >= 2) begin
            ur_exp = 1'b1;
`ifdef I2S_TX_UNDERRUN_ZERO_EN
            cur_l = '0; cur_r = '0;
`endif
          end
          push_frame(cur_l, cur_r);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic       prev_bck;
    logic [1:0] e;
    prev_bck = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bck && !prev_bck) begin
          if (exp_q.size() == 0) begin
            chk_n++; err_n++;
            $display("FAIL bit_stream: bck rise with no expected bit at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("lrck_dout", {30'd0, lrck, dout}, {30'd0, e});
          end
        end
        chk("underrun", {31'd0, underrun}, {31'd0, ur_exp});
      end
      prev_bck = bck;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [23:0] l, input logic [23:0] r);
    int n = 0;
    left = l; right = r; valid = 1'b1;
    while (!ready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    valid = 1'b0;
    chk("ready_drop", {31'd0, ready}, 32'd0);
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while ((cyc % FRAME) != p && n < 600) begin @(negedge clk); n++; end
    if (n >= 600) chk("phase_timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, {27'd0, bck, lrck, dout, underrun, ready}, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; valid = 1'b0; left = '0; right = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk_reset_outs("reset_outs");
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, ready}, 32'd1);

    // directed pair, then back-pressured second pair held on valid
    send(24'hA5A5A5, 24'h3C3C3C);
    send(24'h123456, 24'hFEDCBA);
    // idle long enough for an underrun (repeat of the last pair)
    repeat (2 * FRAME + 20) @(negedge clk);

    // accept exactly on a frame boundary with the buffer empty
    wait_phase(FRAME - 1);
    chk("edge_ready", {31'd0, ready}, 32'd1);
    left = 24'h800001; right = 24'h7FFFFE; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (3 * FRAME) @(negedge clk);

    // random traffic with random gaps
    for (int i = 0; i < 25; i++) begin
      n = $urandom_range(0, 400);
      repeat (n) @(negedge clk);
      send(24'($urandom), 24'($urandom));
    end
    repeat (FRAME) @(negedge clk);

    // reset in the middle of a frame (bitcnt = 40)
    send(24'hFFFFFF, 24'h000001);
    wait_phase(160);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outs("midreset_outs");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_midreset", {31'd0, ready}, 32'd1);
    for (int i = 0; i < 126; i++) begin
      chk("lrck_low_after_reset", {31'd0, lrck}, 32'd0);
      @(negedge clk);
    end
    send(24'($urandom), 24'($urandom));
    repeat (3 * FRAME) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", chk_n, err_n);
    $finish;
  end

endmodule
